// File: rtl/multi_cycle_ctrl_fsm.sv
// multi_cycle_ctrl_fsm: fetch/decode/execute/memory/writeback sequencer for the multi-cycle ARM datapath
// Ports: clk, reset_n (sync, active-low); Op/Funct/cond_ex from the decoder; mem_ready memory handshake;
// mem_req/IRWrite/NextPC/AdrSrc/ALUSrcA/ALUSrcB/ResultSrc datapath controls; ALUOp/Branch/RegW/MemW
// to the decoder and conditional-write logic; illegal_op pulse; retired instruction count; state_dbg.
module multi_cycle_ctrl_fsm #(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               cond_ex,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               IRWrite,
  output logic               NextPC,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               ALUOp,
  output logic               Branch,
  output logic               RegW,
  output logic               MemW,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retired,
  output logic [STATE_W-1:0] state_dbg
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
  } state_e;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             unused_funct;
  assign unused_funct = ^Funct[4:1];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUOp      = 1'b0;
    Branch     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        NextPC    = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // a failed condition retires the instruction as a no-op, ahead of any op decoding
        if (!cond_ex) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else begin
          case (Op)
            2'b00:   state_d = Funct[5] ? EXECI : EXECR;
            2'b01:   state_d = MEMADR;
            2'b10:   state_d = BRANCH;
            default: begin
              state_d    = FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        state_d   = FETCH;
        retire    = 1'b1;
      end
      MEMWR: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        MemW    = 1'b1;
        state_d = mem_ready ? FETCH : MEMWR;
        retire  = mem_ready;
      end
      EXECR: begin
        ALUOp   = 1'b1;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegW    = 1'b1;
        state_d = FETCH;
        retire  = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        state_d   = FETCH;
        retire    = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    retired_d = retire ? retired_q + 1'b1 : retired_q;
    // no strobe or select may reach the datapath while reset is held
    if (!reset_n) begin
      mem_req    = 1'b0;
      IRWrite    = 1'b0;
      NextPC     = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUOp      = 1'b0;
      Branch     = 1'b0;
      RegW       = 1'b0;
      MemW       = 1'b0;
      illegal_op = 1'b0;
    end
  end
  assign retired   = retired_q;
  assign state_dbg = reset_n ? STATE_W'(state_q) : '0;
endmodule

// File: tb/tb_multi_cycle_ctrl_fsm.sv
// tb_multi_cycle_ctrl_fsm: randomized instruction streams checked against a per-instruction trace model
module tb_multi_cycle_ctrl_fsm;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          reset_n, cond_ex, mem_ready;
  logic [1:0]    Op;
  logic [5:0]    Funct;
  logic          mem_req, IRWrite, NextPC, AdrSrc, ALUOp, Branch, RegW, MemW, illegal_op;
  logic [1:0]    ALUSrcA, ALUSrcB, ResultSrc;
  logic [CW-1:0] retired;
  logic [3:0]    state_dbg;
  logic [14:0]   outs;
  logic [CW-1:0] exp_ret;
  int            n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  multi_cycle_ctrl_fsm #(.CNT_W(CW), .STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .cond_ex(cond_ex), .mem_ready(mem_ready),
    .mem_req(mem_req), .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .Branch(Branch), .RegW(RegW),
    .MemW(MemW), .illegal_op(illegal_op), .retired(retired), .state_dbg(state_dbg)
  );
  assign outs = {mem_req, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, Branch, RegW, MemW, illegal_op};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  // control word per state: {mem_req,IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,Branch,RegW,MemW,illegal_op}
  function automatic logic [14:0] exp_out(input int s, input logic r, input logic [1:0] op, input logic c);
    case (s)
      0:       return {1'b1, r, r, 1'b0, 2'b01, 2'b10, 2'b10, 5'b00000};
      1:       return {4'b0000, 2'b01, 2'b10, 2'b10, 4'b0000, c && op == 2'b11};
      2:       return {4'b0000, 2'b00, 2'b01, 2'b00, 5'b00000};
      3:       return {4'b1001, 2'b00, 2'b00, 2'b00, 5'b00000};
      4:       return {4'b0000, 2'b00, 2'b00, 2'b01, 5'b00100};
      5:       return {4'b1001, 2'b00, 2'b00, 2'b00, 5'b00010};
      6:       return {4'b0000, 2'b00, 2'b00, 2'b00, 5'b10000};
      7:       return {4'b0000, 2'b00, 2'b01, 2'b00, 5'b10000};
      8:       return {4'b0000, 2'b00, 2'b00, 2'b00, 5'b00100};
      9:       return {4'b0000, 2'b00, 2'b01, 2'b10, 5'b01000};
      default: return 15'h7fff;
    endcase
  endfunction
  // one instruction: the expected state trace is laid out up front from its class and wait counts
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic c,
                           input int wf, input int wm, input int abort_at);
    int   sq[$];
    logic rq[$];
    for (int k = 0; k < wf; k++) begin sq.push_back(0); rq.push_back(1'b0); end
    sq.push_back(0); rq.push_back(1'b1);
    sq.push_back(1); rq.push_back(1'($urandom));
    if (c) begin
      if (op == 2'b00) begin
        sq.push_back(fn[5] ? 7 : 6); rq.push_back(1'($urandom));
        sq.push_back(8); rq.push_back(1'($urandom));
      end else if (op == 2'b01) begin
        sq.push_back(2); rq.push_back(1'($urandom));
        for (int k = 0; k < wm; k++) begin sq.push_back(fn[0] ? 3 : 5); rq.push_back(1'b0); end
        sq.push_back(fn[0] ? 3 : 5); rq.push_back(1'b1);
        if (fn[0]) begin sq.push_back(4); rq.push_back(1'($urandom)); end
      end else if (op == 2'b10) begin
        sq.push_back(9); rq.push_back(1'($urandom));
      end
    end
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        reset_n = 1'b0; mem_ready = 1'b1; #1;
        check("abort_outs", 32'(outs), 32'd0);
        check("abort_state", 32'(state_dbg), 32'd0);
        exp_ret = '0;
        return;
      end
      reset_n = 1'b1; Op = op; Funct = fn; cond_ex = c; mem_ready = rq[i]; #1;
      check("state", 32'(state_dbg), 32'(sq[i]));
      check("outs", 32'(outs), 32'(exp_out(sq[i], rq[i], op, c)));
      check("retired", 32'(retired), 32'(exp_ret));
    end
    if (!(c && op == 2'b11)) exp_ret = exp_ret + 1'b1;
  endtask
  initial begin
    logic [1:0] op;
    logic       c;
    reset_n = 1'b0; mem_ready = 1'b1; Op = 2'b00; Funct = 6'd0; cond_ex = 1'b1; exp_ret = '0;
    repeat (3) begin
      @(negedge clk); #1;
      check("reset_outs", 32'(outs), 32'd0);
      check("reset_state", 32'(state_dbg), 32'd0);
      check("reset_retired", 32'(retired), 32'd0);
    end
    run_instr(2'b00, 6'b001000, 1'b1, 0, 0, -1);
    run_instr(2'b01, 6'b000001, 1'b1, 2, 2, -1);
    run_instr(2'b01, 6'b000000, 1'b1, 0, 1, -1);
    run_instr(2'b10, 6'b000000, 1'b1, 0, 0, -1);
    run_instr(2'b00, 6'b000000, 1'b0, 0, 0, -1);
    run_instr(2'b11, 6'b000000, 1'b1, 0, 0, -1);
    run_instr(2'b00, 6'b100000, 1'b1, 1, 0, -1);
    run_instr(2'b01, 6'b000001, 1'b1, 0, 2, 4);
    run_instr(2'b10, 6'b000000, 1'b1, 0, 0, -1);
    for (int n = 0; n < 200; n++) begin
      op = 2'($urandom_range(0, 3));
      c  = ($urandom_range(0, 3) != 0) || (op == 2'b11);
      run_instr(op, 6'($urandom), c, $urandom_range(0, 2), $urandom_range(0, 2),
                ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
